// File: rtl/control_pipe.sv
// Pipeline control registers ID/EX -> EX/MEM -> MEM/WB with branch flush and load-use stall.
// Define HAZARD_DETECT_EN to enable load-use detection; otherwise Stall is tied low.
module control_pipe (
    input  logic       clk,
    input  logic       reset,
    input  logic       Branch,
    input  logic       MemRead,
    input  logic       MemToReg,
    input  logic       MemWrite,
    input  logic       ALUSrc,
    input  logic       RegWrite,
    input  logic [1:0] ALUOp,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic [4:0] rd_id,
    input  logic       Zero_ex,
    output logic [1:0] ALUOp_ex,
    output logic       ALUSrc_ex,
    output logic       Branch_mem,
    output logic       MemRead_mem,
    output logic       MemWrite_mem,
    output logic       MemToReg_wb,
    output logic       RegWrite_wb,
    output logic [4:0] rd_ex,
    output logic [4:0] rd_mem,
    output logic [4:0] rd_wb,
    output logic       PCSrc,
    output logic       Stall,
    output logic       Flush
);

    // ID/EX fields that are not outputs
    logic branch_ex, memread_ex, memtoreg_ex, memwrite_ex, regwrite_ex;
    // EX/MEM fields that are not outputs
    logic memtoreg_mem, regwrite_mem, zero_mem;
    logic load_use;

    assign PCSrc = Branch_mem & zero_mem;
    assign Flush = PCSrc;

`ifdef HAZARD_DETECT_EN
    assign load_use = memread_ex && (rd_ex != 5'd0) &&
                      ((rd_ex == rs1_id) || (rd_ex == rs2_id));
`else
    logic unused_rs;
    assign unused_rs = ^{rs1_id, rs2_id};
    assign load_use  = 1'b0;
`endif

    // A taken branch squashes the younger load, so flush wins over stall
    assign Stall = load_use & ~PCSrc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_ex    <= 1'b0;
            memread_ex   <= 1'b0;
            memtoreg_ex  <= 1'b0;
            memwrite_ex  <= 1'b0;
            regwrite_ex  <= 1'b0;
            ALUSrc_ex    <= 1'b0;
            ALUOp_ex     <= 2'b00;
            rd_ex        <= 5'd0;
            Branch_mem   <= 1'b0;
            MemRead_mem  <= 1'b0;
            MemWrite_mem <= 1'b0;
            memtoreg_mem <= 1'b0;
            regwrite_mem <= 1'b0;
            zero_mem     <= 1'b0;
            rd_mem       <= 5'd0;
            MemToReg_wb  <= 1'b0;
            RegWrite_wb  <= 1'b0;
            rd_wb        <= 5'd0;
        end else begin
            MemToReg_wb <= memtoreg_mem;
            RegWrite_wb <= regwrite_mem;
            rd_wb       <= rd_mem;
            if (Flush) begin
                branch_ex    <= 1'b0;
                memread_ex   <= 1'b0;
                memtoreg_ex  <= 1'b0;
                memwrite_ex  <= 1'b0;
                regwrite_ex  <= 1'b0;
                ALUSrc_ex    <= 1'b0;
                ALUOp_ex     <= 2'b00;
                rd_ex        <= 5'd0;
                Branch_mem   <= 1'b0;
                MemRead_mem  <= 1'b0;
                MemWrite_mem <= 1'b0;
                memtoreg_mem <= 1'b0;
                regwrite_mem <= 1'b0;
                zero_mem     <= 1'b0;
                rd_mem       <= 5'd0;
            end else begin
                Branch_mem   <= branch_ex;
                MemRead_mem  <= memread_ex;
                MemWrite_mem <= memwrite_ex;
                memtoreg_mem <= memtoreg_ex;
                regwrite_mem <= regwrite_ex;
                zero_mem     <= Zero_ex;
                rd_mem       <= rd_ex;
                if (Stall) begin
                    branch_ex   <= 1'b0;
                    memread_ex  <= 1'b0;
                    memtoreg_ex <= 1'b0;
                    memwrite_ex <= 1'b0;
                    regwrite_ex <= 1'b0;
                    ALUSrc_ex   <= 1'b0;
                    ALUOp_ex    <= 2'b00;
                    rd_ex       <= 5'd0;
                end else begin
                    branch_ex   <= Branch;
                    memread_ex  <= MemRead;
                    memtoreg_ex <= MemToReg;
                    memwrite_ex <= MemWrite;
                    regwrite_ex <= RegWrite;
                    ALUSrc_ex   <= ALUSrc;
                    ALUOp_ex    <= ALUOp;
                    rd_ex       <= rd_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: instruction-record pipeline model plus directed vectors.
module tb_control_pipe;

`ifdef HAZARD_DETECT_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Branch = 0, MemRead = 0, MemToReg = 0, MemWrite = 0, ALUSrc = 0, RegWrite = 0;
    logic [1:0] ALUOp = 0;
    logic [4:0] rs1_id = 0, rs2_id = 0, rd_id = 0;
    logic       Zero_ex = 0;
    logic [1:0] ALUOp_ex;
    logic       ALUSrc_ex, Branch_mem, MemRead_mem, MemWrite_mem, MemToReg_wb, RegWrite_wb;
    logic [4:0] rd_ex, rd_mem, rd_wb;
    logic       PCSrc, Stall, Flush;

    int total = 0;
    int bad = 0;

    control_pipe dut (
        .clk(clk), .reset(reset),
        .Branch(Branch), .MemRead(MemRead), .MemToReg(MemToReg), .MemWrite(MemWrite),
        .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .Zero_ex(Zero_ex),
        .ALUOp_ex(ALUOp_ex), .ALUSrc_ex(ALUSrc_ex),
        .Branch_mem(Branch_mem), .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem),
        .MemToReg_wb(MemToReg_wb), .RegWrite_wb(RegWrite_wb),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .PCSrc(PCSrc), .Stall(Stall), .Flush(Flush)
    );

    always #5 clk = ~clk;

    // one instruction's control word as it travels down the pipe
    typedef struct packed {
        logic       br, mr, m2r, mw, as, rw;
        logic [1:0] op;
        logic [4:0] rd;
    } ins_t;

    ins_t m_ex, m_mem, m_wb;
    logic m_zero;

    function automatic ins_t id_ins();
        ins_t t;
        t.br = Branch; t.mr = MemRead; t.m2r = MemToReg; t.mw = MemWrite;
        t.as = ALUSrc; t.rw = RegWrite; t.op = ALUOp; t.rd = rd_id;
        return t;
    endfunction

    function automatic logic taken();
        return m_mem.br && m_zero;
    endfunction

    function automatic logic hazard();
        if (!HAZ || taken()) return 1'b0;
        return m_ex.mr && m_ex.rd != 0 && (m_ex.rd == rs1_id || m_ex.rd == rs2_id);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ex <= '0; m_mem <= '0; m_wb <= '0; m_zero <= 1'b0;
        end else begin
            m_wb <= m_mem;
            if (taken()) begin
                m_mem <= '0; m_ex <= '0; m_zero <= 1'b0;
            end else begin
                m_mem  <= m_ex;
                m_zero <= Zero_ex;
                m_ex   <= hazard() ? '0 : id_ins();
            end
        end
    end

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ALUOp_ex", 5'(ALUOp_ex), 5'(m_ex.op));
        chk("ALUSrc_ex", 5'(ALUSrc_ex), 5'(m_ex.as));
        chk("rd_ex", rd_ex, m_ex.rd);
        chk("Branch_mem", 5'(Branch_mem), 5'(m_mem.br));
        chk("MemRead_mem", 5'(MemRead_mem), 5'(m_mem.mr));
        chk("MemWrite_mem", 5'(MemWrite_mem), 5'(m_mem.mw));
        chk("rd_mem", rd_mem, m_mem.rd);
        chk("MemToReg_wb", 5'(MemToReg_wb), 5'(m_wb.m2r));
        chk("RegWrite_wb", 5'(RegWrite_wb), 5'(m_wb.rw));
        chk("rd_wb", rd_wb, m_wb.rd);
        chk("PCSrc", 5'(PCSrc), 5'(taken()));
        chk("Flush", 5'(Flush), 5'(taken()));
        chk("Stall", 5'(Stall), 5'(hazard()));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Branch = 0; MemRead = 0; MemToReg = 0; MemWrite = 0; ALUSrc = 0; RegWrite = 0;
        ALUOp = 0; rs1_id = 0; rs2_id = 0; rd_id = 0; Zero_ex = 0;
    endtask

    task automatic drain();
        idle();
        repeat (4) step();
    endtask

    initial begin
        step();
        chk("reset rd_wb", rd_wb, 5'd0);
        chk("reset PCSrc", 5'(PCSrc), 5'd0);
        step();
        reset = 1'b0;

        // R-type
        RegWrite = 1; ALUOp = 2'b10; rd_id = 5'd5;
        step(); idle();
        chk("rtype ALUOp_ex", 5'(ALUOp_ex), 5'd2);
        step();
        chk("rtype rd_mem", rd_mem, 5'd5);
        step();
        chk("rtype RegWrite_wb", 5'(RegWrite_wb), 5'd1);
        chk("rtype rd_wb", rd_wb, 5'd5);
        drain();

        // load-use
        MemRead = 1; MemToReg = 1; RegWrite = 1; rd_id = 5'd7;
        step();
        MemRead = 0; MemToReg = 0; RegWrite = 1; ALUOp = 2'b10; rs1_id = 5'd7; rd_id = 5'd8;
        #1;
        chk("loaduse Stall", 5'(Stall), 5'(HAZ));
        step();
        chk("loaduse ALUOp_ex", 5'(ALUOp_ex), HAZ ? 5'd0 : 5'd2);
        chk("loaduse rd_ex", rd_ex, HAZ ? 5'd0 : 5'd8);
        chk("loaduse Stall released", 5'(Stall), 5'd0);
        step();
        chk("loaduse R in EX", rd_ex, 5'd8);
        drain();

        // taken beq with a younger instruction squashed
        Branch = 1; ALUOp = 2'b01;
        step();
        idle(); Zero_ex = 1; ALUSrc = 1; ALUOp = 2'b10; RegWrite = 1; rd_id = 5'd4;
        step();
        Zero_ex = 0; ALUOp = 2'b11; rd_id = 5'd6;
        chk("beq PCSrc", 5'(PCSrc), 5'd1);
        chk("beq Flush", 5'(Flush), 5'd1);
        step(); idle();
        chk("beq ALUOp_ex", 5'(ALUOp_ex), 5'd0);
        chk("beq ALUSrc_ex", 5'(ALUSrc_ex), 5'd0);
        chk("beq Branch_mem", 5'(Branch_mem), 5'd0);
        chk("beq rd_mem", rd_mem, 5'd0);
        drain();

        // load in EX and taken branch in MEM together
        Branch = 1; ALUOp = 2'b01;
        step();
        idle(); Zero_ex = 1; MemRead = 1; MemToReg = 1; RegWrite = 1; rd_id = 5'd3;
        step();
        idle(); RegWrite = 1; rs2_id = 5'd3; rd_id = 5'd10;
        #1;
        chk("simul Flush", 5'(Flush), 5'd1);
        chk("simul Stall", 5'(Stall), 5'd0);
        step(); idle();
        drain();

        // load into x0
        MemRead = 1; MemToReg = 1; RegWrite = 1; rd_id = 5'd0;
        step();
        idle(); rs1_id = 5'd0; RegWrite = 1; rd_id = 5'd2;
        #1;
        chk("x0 Stall", 5'(Stall), 5'd0);
        drain();

        // asynchronous reset mid-stream
        RegWrite = 1; ALUOp = 2'b10; rd_id = 5'd9;
        step(); idle();
        step();
        step();
        chk("pre-reset rd_wb", rd_wb, 5'd9);
        chk("pre-reset RegWrite_wb", 5'(RegWrite_wb), 5'd1);
        RegWrite = 1; rd_id = 5'd11;
        #1 reset = 1'b1;
        #1;
        chk("async reset RegWrite_wb", 5'(RegWrite_wb), 5'd0);
        chk("async reset rd_wb", rd_wb, 5'd0);
        chk("async reset rd_ex", rd_ex, 5'd0);
        step();
        reset = 1'b0;
        step(); idle();
        chk("post-reset capture", rd_ex, 5'd11);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below (clock and reset first).
REQ-002 clk  in  1  rising-edge clock for all stage registers.
REQ-003 reset  in  1  asynchronous active-high clear of all stage registers.
REQ-004 Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite  in  1 each  ID-stage control bits from the control unit.
REQ-005 ALUOp  in  2  ID-stage ALU operation class.
REQ-006 rs1_id, rs2_id, rd_id  in  5 each  register fields of the instruction in ID.
REQ-007 Zero_ex  in  1  ALU zero flag of the instruction in EX.
REQ-008 ALUOp_ex  out  2;  ALUSrc_ex  out  1  EX-stage controls.
REQ-009 Branch_mem, MemRead_mem, MemWrite_mem  out  1 each  MEM-stage controls.
REQ-010 MemToReg_wb, RegWrite_wb  out  1 each  WB-stage controls.
REQ-011 rd_ex, rd_mem, rd_wb  out  5 each  destination register per stage.
REQ-012 PCSrc  out  1  taken-branch redirect.
REQ-013 Stall  out  1  hold PC and IF/ID.
REQ-014 Flush  out  1  squash IF/ID.

Function
REQ-015 Three stage registers SHALL exist: ID/EX (all 8 control bits + rd), EX/MEM (Branch, MemRead, MemWrite, MemToReg, RegWrite, zero, rd), MEM/WB (MemToReg, RegWrite, rd).
REQ-016 Each rising clk edge SHALL advance ID->ID/EX->EX/MEM->MEM/WB; latency ID input to WB output is 3 edges.
REQ-017 EX/MEM zero SHALL capture Zero_ex on the same edge that ID/EX advances into EX/MEM.
REQ-018 PCSrc SHALL be combinational: EX/MEM Branch AND EX/MEM zero.
REQ-019 Flush SHALL equal PCSrc.
REQ-020 Stall SHALL be combinational: ID/EX MemRead AND rd_ex != 0 AND (rd_ex == rs1_id OR rd_ex == rs2_id) AND NOT PCSrc.
REQ-021 On an edge with Stall=1, ID/EX SHALL load a bubble (all controls 0, rd 0); EX/MEM and MEM/WB SHALL advance normally.
REQ-022 On an edge with Flush=1, ID/EX and EX/MEM control fields and rd SHALL load 0; MEM/WB SHALL advance normally.
REQ-023 When stall and flush conditions occur together, flush SHALL take precedence and Stall SHALL read 0.
REQ-024 A load into x0 (rd_ex = 0) SHALL never cause a stall.
REQ-025 All outputs SHALL be direct register fields or the combinational terms above; no other logic on output paths.

Reset
REQ-026 While reset=1, all stage registers SHALL clear immediately, independent of clk.
REQ-027 During reset, every output SHALL read 0, including PCSrc, Stall and Flush.
REQ-028 After reset deasserts, the first rising edge SHALL capture ID inputs normally.

Configuration
REQ-029 Macro HAZARD_DETECT_EN, when defined, SHALL enable load-use detection per REQ-020/REQ-021.
REQ-030 Without HAZARD_DETECT_EN, Stall SHALL be tied to 0 and no load-use bubbles SHALL be inserted; flush behaviour is unchanged.

Verification
REQ-031 R-type: RegWrite=1, ALUOp=10, rd_id=5 for one cycle -> ALUOp_ex=10 after edge 1; rd_mem=5 after edge 2; RegWrite_wb=1 and rd_wb=5 after edge 3.
REQ-032 Load-use: lw (MemRead=1, MemToReg=1, rd_id=7), then R-type with rs1_id=7 -> Stall=1 for exactly one cycle; ID/EX all zero on the next edge; R-type reaches EX one edge later (with HAZARD_DETECT_EN).
REQ-033 beq taken: Branch=1, ALUOp=01, with Zero_ex=1 while in EX -> PCSrc=1 and Flush=1 after edge 2; after edge 3, ALUOp_ex=00, ALUSrc_ex=0, Branch_mem=0.
REQ-034 Simultaneous: load with rd=3 in ID/EX, rs2_id=3, while a taken branch is in EX/MEM -> Flush=1, Stall=0.
REQ-035 x0 load: lw with rd_id=0 followed by rs1_id=0 -> Stall stays 0.
REQ-036 Reset mid-stream with RegWrite_wb=1, rd_wb=9 -> all outputs 0 within the same cycle, before the next clk edge.
